// File: rtl/part_tester_host_pkg.sv
// Shared definitions for the part tester host: ASCII framing constants,
// FSM state encoding and the hex digit-count helper.
package part_tester_host_pkg;

  localparam logic [7:0] CMD_V = 8'h56;
  localparam logic [7:0] CR    = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic int pt_digits(input int bits);
    return (bits + 32'sd3) / 32'sd4;
  endfunction

endpackage

// File: rtl/part_tester_host_hex_ascii.sv
// Combinational hex/ASCII converter: nibble to uppercase ASCII, and ASCII
// (0-9, A-F, a-f) to nibble with a validity flag.
module hex_ascii (
  input  logic [3:0] enc_nib,
  output logic [7:0] enc_char,
  input  logic [7:0] dec_char,
  output logic [3:0] dec_nib,
  output logic       dec_is_hex
);

  // nibble to uppercase ASCII digit
  always_comb begin
    if (enc_nib < 4'd10) enc_char = 8'h30 + {4'h0, enc_nib};
    else                 enc_char = 8'h37 + {4'h0, enc_nib};
  end

  // ASCII digit to nibble; letters of either case share the low nibble + 9
  always_comb begin
    dec_nib    = 4'h0;
    dec_is_hex = 1'b0;
    if (dec_char >= 8'h30 && dec_char <= 8'h39) begin
      dec_nib    = dec_char[3:0];
      dec_is_hex = 1'b1;
    end else if ((dec_char >= 8'h41 && dec_char <= 8'h46) ||
                 (dec_char >= 8'h61 && dec_char <= 8'h66)) begin
      dec_nib    = dec_char[3:0] + 4'd9;
      dec_is_hex = 1'b1;
    end else begin
      dec_nib    = 4'h0;
      dec_is_hex = 1'b0;
    end
  end

endmodule

// File: rtl/part_tester_host.sv
// Host-side initiator: sends 'V'+hex+CR, checks the echo, parses the PO reply.
// Optional rx inactivity timeout is built when PT_HOST_TIMEOUT_EN is defined.
module part_tester_host
  import part_tester_host_pkg::*;
#(
  parameter int NPIS           = 14,
  parameter int NPOS           = 11,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vec_valid_i,
  output logic            vec_ready_o,
  input  logic [NPIS-1:0] vec_pis_i,
  input  logic [NPOS-1:0] vec_exp_i,
  output logic            tx_start_o,
  output logic [7:0]      tx_data_o,
  input  logic            tx_ready_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_rcv_i,
  output logic            res_valid_o,
  output logic [NPOS-1:0] res_pos_o,
  output logic            res_pass_o,
  output logic [2:0]      res_err_o,
  output logic            busy_o
);

  localparam int DPI      = pt_digits(NPIS);
  localparam int DPO      = pt_digits(NPOS);
  localparam int CMD_LEN  = DPI + 2;
  localparam int RX_TOTAL = CMD_LEN + DPO + 1;
  localparam int IW       = $clog2(RX_TOTAL + 1);
  localparam int PIW      = 4 * DPI;
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] TX_LAST   = IW'(CMD_LEN - 1);
  localparam logic [IW-1:0] RSP_FIRST = IW'(CMD_LEN);
  localparam logic [IW-1:0] RSP_CR    = IW'(RX_TOTAL - 1);
  localparam logic [IW-1:0] RX_END    = IW'(RX_TOTAL);

  state_t          state_r, state_next_s;
  logic [NPIS-1:0] pis_r;
  logic [NPOS-1:0] exp_r;
  logic [IW-1:0]   tx_idx_r, rx_idx_r;
  logic            pending_r;
  logic [2:0]      err_r, err_next_s;
  logic [NPOS-1:0] pos_acc_r, pos_next_s;
  logic [PIW-1:0]  pis_pad_s;
  logic [3:0]      tx_nib_s, rx_exp_nib_s, rx_nib_s;
  logic [7:0]      tx_asc_s, tx_byte_s;
  logic            rx_is_hex_s, echo_ok_s;
  logic            accept_s, tx_fire_s, rx_take_s, timeout_s;
  logic            tx_start_r, vec_ready_r, busy_r, res_valid_r, res_pass_r;
  logic [7:0]      tx_data_r;
  logic [NPOS-1:0] res_pos_r;
  logic [2:0]      res_err_r;

  hex_ascii u_hex (
    .enc_nib    (tx_nib_s),
    .enc_char   (tx_asc_s),
    .dec_char   (rx_data_i),
    .dec_nib    (rx_nib_s),
    .dec_is_hex (rx_is_hex_s)
  );

  assign pis_pad_s = PIW'(pis_r);

  // digit k of the command (1-based, MSB first) for both the tx and rx indices
  always_comb begin
    tx_nib_s     = 4'h0;
    rx_exp_nib_s = 4'h0;
    for (int k = 1; k <= DPI; k++) begin
      tx_nib_s     = (int'(tx_idx_r) == k) ? pis_pad_s[4*(DPI-k) +: 4] : tx_nib_s;
      rx_exp_nib_s = (int'(rx_idx_r) == k) ? pis_pad_s[4*(DPI-k) +: 4] : rx_exp_nib_s;
    end
  end

`ifdef PT_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  logic [TW-1:0] to_cnt_r;

  // idle-rx cycle counter, restarted at vector accept and on every rx byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        to_cnt_r <= {TW{1'b0}};
    else if (accept_s || rx_rcv_i)  to_cnt_r <= {TW{1'b0}};
    else if ((state_r == ST_SEND || state_r == ST_WAIT_RX) && !timeout_s)
                                    to_cnt_r <= to_cnt_r + TMO_ONE;
    else                            to_cnt_r <= to_cnt_r;
  end

  assign timeout_s = (state_r == ST_SEND || state_r == ST_WAIT_RX) &&
                     (to_cnt_r == TW'(TIMEOUT_CYCLES));
`else
  assign timeout_s = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:    state_next_s = vec_valid_i ? ST_SEND : ST_IDLE;
      ST_SEND: begin
        if (timeout_s)                             state_next_s = ST_DONE;
        else if (tx_fire_s && tx_idx_r == TX_LAST) state_next_s = ST_WAIT_RX;
        else                                       state_next_s = ST_SEND;
      end
      ST_WAIT_RX: begin
        if (timeout_s || rx_idx_r == RX_END) state_next_s = ST_DONE;
        else                                 state_next_s = ST_WAIT_RX;
      end
      ST_DONE:    state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // control strobes, tx byte selection and rx checking
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && vec_valid_i;
    tx_fire_s = (state_r == ST_SEND) && tx_ready_i && !pending_r && !timeout_s;
    rx_take_s = rx_rcv_i && (state_r == ST_SEND || state_r == ST_WAIT_RX) && (rx_idx_r < RX_END);

    if (tx_idx_r == {IW{1'b0}}) tx_byte_s = CMD_V;
    else if (tx_idx_r == TX_LAST) tx_byte_s = CR;
    else tx_byte_s = tx_asc_s;

    // echo digits must come back uppercase, exactly as sent
    if (rx_idx_r == {IW{1'b0}}) echo_ok_s = (rx_data_i == CMD_V);
    else if (rx_idx_r == TX_LAST) echo_ok_s = (rx_data_i == CR);
    else echo_ok_s = rx_is_hex_s && (rx_nib_s == rx_exp_nib_s) && (rx_data_i < 8'h61);

    err_next_s = err_r;
    pos_next_s = pos_acc_r;
    if (rx_take_s) begin
      if (rx_idx_r < RSP_FIRST) begin
        err_next_s[0] = err_r[0] | ~echo_ok_s;
      end else if (rx_idx_r < RSP_CR) begin
        err_next_s[1] = err_r[1] | ~rx_is_hex_s;
        pos_next_s    = NPOS'({pos_acc_r, (rx_is_hex_s ? rx_nib_s : 4'h0)});
      end else begin
        err_next_s[1] = err_r[1] | (rx_data_i != CR);
      end
    end else begin
      pos_next_s = pos_acc_r;
    end
    err_next_s[2] = err_r[2] | timeout_s;
  end

  // transaction datapath: latched vector, indices, handshake and accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pis_r <= {NPIS{1'b0}}; exp_r <= {NPOS{1'b0}};
      tx_idx_r <= {IW{1'b0}}; rx_idx_r <= {IW{1'b0}};
      pending_r <= 1'b0; err_r <= 3'b000; pos_acc_r <= {NPOS{1'b0}};
    end else if (accept_s) begin
      pis_r <= vec_pis_i; exp_r <= vec_exp_i;
      tx_idx_r <= {IW{1'b0}}; rx_idx_r <= {IW{1'b0}};
      pending_r <= 1'b0; err_r <= 3'b000; pos_acc_r <= {NPOS{1'b0}};
    end else begin
      tx_idx_r  <= tx_fire_s ? tx_idx_r + IDX_ONE : tx_idx_r;
      pending_r <= tx_fire_s | (pending_r & tx_ready_i);
      rx_idx_r  <= rx_take_s ? rx_idx_r + IDX_ONE : rx_idx_r;
      err_r     <= err_next_s;
      pos_acc_r <= pos_next_s;
    end
  end

  // registered outputs; results are published the cycle after DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start_r <= 1'b0; tx_data_r <= 8'h00;
      vec_ready_r <= 1'b1; busy_r <= 1'b0;
      res_valid_r <= 1'b0; res_pos_r <= {NPOS{1'b0}};
      res_pass_r <= 1'b0; res_err_r <= 3'b000;
    end else begin
      tx_start_r  <= tx_fire_s;
      tx_data_r   <= tx_fire_s ? tx_byte_s : tx_data_r;
      vec_ready_r <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE);
      res_valid_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        res_pos_r  <= pos_acc_r;
        res_err_r  <= err_r;
        res_pass_r <= (err_r == 3'b000) && (pos_acc_r == exp_r);
      end else begin
        res_pos_r  <= res_pos_r;
        res_err_r  <= res_err_r;
        res_pass_r <= res_pass_r;
      end
    end
  end

  assign tx_start_o  = tx_start_r;
  assign tx_data_o   = tx_data_r;
  assign vec_ready_o = vec_ready_r;
  assign busy_o      = busy_r;
  assign res_valid_o = res_valid_r;
  assign res_pos_o   = res_pos_r;
  assign res_pass_o  = res_pass_r;
  assign res_err_o   = res_err_r;

endmodule
